// File: rtl/decode_feed_if.sv
// Signal bundle between fetch, the decode feed buffer, decode/rename and the ROB.
interface decode_feed_if #(
   parameter int FETCH_W = 2,
   parameter int DEPTH   = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [FETCH_W-1:0]       fetch_valid;
   logic [FETCH_W-1:0][31:0] fetch_instr;
   logic [FETCH_W-1:0][31:0] fetch_pc;
   logic                     fetch_ready;
   logic                     decode_ready;
   logic                     flush_pipeline;
   logic                     rob_empty;
   logic [FETCH_W-1:0]       instr_valid;
   logic [FETCH_W-1:0][31:0] instr;
   logic [FETCH_W-1:0][31:0] pc;
   logic [CNT_W-1:0]         q_count;
   logic                     serial_stall;

   // Fetch unit, decoder and ROB status driving the buffer.
   modport master (
      output fetch_valid, fetch_instr, fetch_pc, decode_ready, flush_pipeline, rob_empty,
      input  fetch_ready, instr_valid, instr, pc, q_count, serial_stall
   );

   // The buffer itself.
   modport slave (
      input  fetch_valid, fetch_instr, fetch_pc, decode_ready, flush_pipeline, rob_empty,
      output fetch_ready, instr_valid, instr, pc, q_count, serial_stall
   );
endinterface

// File: rtl/decode_feed_ctrl.sv
// In-order instruction buffer between fetch and decode. Absorbs up to FETCH_W
// instructions per cycle into a circular queue, presents up to FETCH_W of the
// oldest entries to the decoder, and issues CAS/system instructions alone,
// only once the ROB has drained.
module decode_feed_ctrl #(
   parameter int FETCH_W  = 2,
   parameter int DEPTH    = 8,
   parameter int HOLD_MIN = 4
) (
   input  logic         clk,
   input  logic         reset,
   decode_feed_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int HC_W  = $clog2(HOLD_MIN + 1);

   localparam logic [5:0] OP_CAS = 6'b010100;
   localparam logic [5:0] OP_SYS = 6'b111000;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HOLD
   } state_t;

   state_t                        state_q, state_d;
   logic [HC_W-1:0]               hold_q, hold_d;
   logic [PTR_W-1:0]              head_q, tail_q;
   logic [CNT_W-1:0]              count_q;
   logic [31:0]                   mem_instr [DEPTH];
   logic [31:0]                   mem_pc    [DEPTH];

   logic                          push_en;
   logic                          pop_en;
   logic                          head_serial;
   logic                          slot_stop;
   logic [CNT_W-1:0]              push_num;
   logic [CNT_W-1:0]              pop_num;
   logic [FETCH_W-1:0]            slot_valid;
   logic [FETCH_W-1:0][PTR_W-1:0] slot_idx;

   // Instructions that must wait for an empty ROB and issue alone.
   function automatic logic is_serial(input logic [31:0] word);
      return (word[31:26] == OP_CAS) || (word[31:26] == OP_SYS);
   endfunction

   // Room for a whole fetch group, judged from registered occupancy only.
   assign bus.fetch_ready  = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
   assign push_en          = bus.fetch_ready && !bus.flush_pipeline;
   assign pop_en           = bus.decode_ready && !bus.flush_pipeline;
   assign bus.instr_valid  = slot_valid;
   assign bus.q_count      = count_q;
   assign bus.serial_stall = (state_q != ST_RUN);

   // Choose presented slots: oldest first, cut at any serialising entry.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      slot_valid  = '0;
      slot_stop   = 1'b0;
      head_serial = (count_q != '0) && is_serial(mem_instr[head_q]);
      for (int k = 0; k < FETCH_W; k++) begin
         slot_idx[k] = head_q + PTR_W'(k);
         if (!slot_stop && (CNT_W'(k) < count_q)) begin
            if (!is_serial(mem_instr[slot_idx[k]])) begin
               slot_valid[k] = 1'b1;
            end else begin
               // A serialising entry only issues from slot 0 once the ROB is empty.
               slot_valid[k] = (k == 0) && bus.rob_empty;
               slot_stop     = 1'b1;
            end
         end
      end
      if ((state_q != ST_RUN) || bus.flush_pipeline) begin
         slot_valid = '0;
      end
   end

   // Drive presented data, zeroed on invalid slots.
   always_comb begin
      for (int k = 0; k < FETCH_W; k++) begin
         bus.instr[k] = slot_valid[k] ? mem_instr[slot_idx[k]] : '0;
         bus.pc[k]    = slot_valid[k] ? mem_pc[slot_idx[k]]    : '0;
      end
   end

   // Count accepted fetch lanes and consumed decode slots.
   always_comb begin
      push_num = '0;
      pop_num  = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         if (bus.fetch_valid[i]) push_num = push_num + CNT_W'(1);
         if (slot_valid[i])      pop_num  = pop_num + CNT_W'(1);
      end
      if (!push_en) push_num = '0;
      if (!pop_en)  pop_num  = '0;
   end

   // Queue pointers and occupancy; flush empties the queue.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (bus.flush_pipeline) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PTR_W'(pop_num);
         tail_q  <= tail_q + PTR_W'(push_num);
         count_q <= count_q + push_num - pop_num;
      end
   end

   // Write accepted fetch lanes in lane order starting at the tail.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the storage array is cleared on reset so a fresh buffer never shows stale words.
         for (int i = 0; i < DEPTH; i++) begin
            mem_instr[i] <= '0;
            mem_pc[i]    <= '0;
         end
      end else if (push_en) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (bus.fetch_valid[i]) begin
               mem_instr[tail_q + PTR_W'(i)] <= bus.fetch_instr[i];
               mem_pc[tail_q + PTR_W'(i)]    <= bus.fetch_pc[i];
            end
         end
      end
   end

   // Serialisation FSM state and post-issue hold counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Next state: drain the ROB before a serialising head, hold after issuing it.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         ST_RUN: begin
            if (head_serial) begin
               if (!bus.rob_empty) begin
                  state_d = ST_DRAIN;
               end else if (bus.decode_ready) begin
                  state_d = ST_HOLD;
                  hold_d  = HC_W'(HOLD_MIN);
               end
            end
         end
         ST_DRAIN: begin
            if (bus.rob_empty) state_d = ST_RUN;
         end
         ST_HOLD: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HC_W'(1);
            end else if (bus.rob_empty) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            hold_d  = '0;
         end
      endcase
      if (bus.flush_pipeline) begin
         state_d = ST_RUN;
         hold_d  = '0;
      end
   end
endmodule
